// File: rtl/bus_arbiter.sv
// bus_arbiter: serialises single-beat requests from two masters onto one bus.
// One-deep request slot per master, round-robin on ties, bounded bus locking.
`timescale 1ns/1ps
module bus_arbiter #(
   parameter int unsigned DW        = 32,
   parameter int unsigned AW        = 32,
   parameter int unsigned MAX_LOCK  = 8,
   parameter int unsigned LOCK_WAIT = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic [AW-1:0] m0_addr,
   input  logic          m0_we,
   input  logic [DW-1:0] m0_wdata,
   input  logic          m0_lock,
   output logic          m0_busy,
   output logic          m0_ack,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic [AW-1:0] m1_addr,
   input  logic          m1_we,
   input  logic [DW-1:0] m1_wdata,
   input  logic          m1_lock,
   output logic          m1_busy,
   output logic          m1_ack,
   output logic [DW-1:0] m1_rdata,
   output logic [AW-1:0] bus_addr,
   output logic          bus_we,
   output logic [DW-1:0] bus_wdata,
   input  logic [DW-1:0] bus_rdata
);

   localparam int unsigned LCW = $clog2(MAX_LOCK + 1);
   localparam int unsigned WCW = $clog2(LOCK_WAIT + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          we;
      logic [DW-1:0] wdata;
      logic          lock;
   } slot_t;

   state_t         state, nextState;
   slot_t          reqSlot [2];
   logic [1:0]     reqIn;
   slot_t          slot [2];
   logic [1:0]     slotFull;
   logic [1:0]     slotClear;
   logic           lastGrant, nextLastGrant;
   logic           lockValid, nextLockValid;
   logic           lockOwner, nextLockOwner;
   logic [LCW-1:0] lockCount, nextLockCount;
   logic [WCW-1:0] waitCount, nextWaitCount;
   logic [1:0]     eligible;
   logic           grantValid;
   logic           grantSel;
   logic [AW-1:0]  busAddr;
   logic           busWe;
   logic [DW-1:0]  busWdata;
   logic [1:0]     ack;
   logic [DW-1:0]  rdata [2];

   // Gather per-master request inputs into indexable form
   assign reqIn      = {m1_req, m0_req};
   assign reqSlot[0] = {m0_addr, m0_we, m0_wdata, m0_lock};
   assign reqSlot[1] = {m1_addr, m1_we, m1_wdata, m1_lock};

   // State and arbitration bookkeeping registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         lastGrant <= 1'b1;
         lockValid <= 1'b0;
         lockOwner <= 1'b0;
         lockCount <= '0;
         waitCount <= '0;
      end else begin
         state     <= nextState;
         lastGrant <= nextLastGrant;
         lockValid <= nextLockValid;
         lockOwner <= nextLockOwner;
         lockCount <= nextLockCount;
         waitCount <= nextWaitCount;
      end
   end

   // Next-state, grant selection and lock bookkeeping
   always_comb begin
      nextState     = state;
      nextLastGrant = lastGrant;
      nextLockValid = lockValid;
      nextLockOwner = lockOwner;
      nextLockCount = lockCount;
      nextWaitCount = waitCount;
      eligible      = 2'b00;
      grantValid    = 1'b0;
      grantSel      = 1'b0;
      slotClear     = 2'b00;
      unique case (state)
         IDLE: begin
            eligible = slotFull;
            if (lockValid) begin
               if (slotFull[lockOwner]) begin
                  eligible            = 2'b00;
                  eligible[lockOwner] = 1'b1;
                  nextWaitCount       = '0;
               end else if (waitCount == WCW'(LOCK_WAIT - 1)) begin
                  // owner left its slot empty too long: drop lock, arbitrate now
                  nextLockValid = 1'b0;
                  nextLockCount = '0;
                  nextWaitCount = '0;
               end else begin
                  eligible      = 2'b00;
                  nextWaitCount = waitCount + WCW'(1);
               end
            end
            grantValid = |eligible;
            // both eligible: the master that did not win last time
            grantSel   = eligible[1] & (~eligible[0] | ~lastGrant);
            if (grantValid) begin
               nextState     = ACCESS;
               nextLastGrant = grantSel;
            end
         end
         ACCESS: nextState = WAIT;
         WAIT: begin
            nextState            = IDLE;
            slotClear[lastGrant] = 1'b1;
            nextWaitCount        = '0;
            if (slot[lastGrant].lock && ((lockCount + LCW'(1)) < LCW'(MAX_LOCK))) begin
               nextLockValid = 1'b1;
               nextLockOwner = lastGrant;
               nextLockCount = lockCount + LCW'(1);
            end else begin
               nextLockValid = 1'b0;
               nextLockCount = '0;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Request slots: a new request in the clearing cycle wins over the clear
   always_ff @(posedge clk) begin
      if (!reset) begin
         slotFull <= '0;
         for (int n = 0; n < 2; n++) slot[n] <= '0;
      end else begin
         for (int n = 0; n < 2; n++) begin
            if (reqIn[n] && (!slotFull[n] || slotClear[n])) begin
               slot[n]     <= reqSlot[n];
               slotFull[n] <= 1'b1;
            end else if (slotClear[n]) begin
               slotFull[n] <= 1'b0;
            end
         end
      end
   end

   // Bus registers: loaded on grant, strobe dropped after ACCESS, zeroed after WAIT
   always_ff @(posedge clk) begin
      if (!reset) begin
         busAddr  <= '0;
         busWe    <= 1'b0;
         busWdata <= '0;
      end else if (grantValid) begin
         busAddr  <= slot[grantSel].addr;
         busWe    <= slot[grantSel].we;
         busWdata <= slot[grantSel].wdata;
      end else if (state == ACCESS) begin
         busWe    <= 1'b0;
      end else if (state == WAIT) begin
         busAddr  <= '0;
         busWe    <= 1'b0;
         busWdata <= '0;
      end
   end

   // Completion pulse and read-data capture for the granted master
   always_ff @(posedge clk) begin
      if (!reset) begin
         ack      <= '0;
         rdata[0] <= '0;
         rdata[1] <= '0;
      end else begin
         ack <= '0;
         if (state == WAIT) begin
            ack[lastGrant] <= 1'b1;
            if (!slot[lastGrant].we) rdata[lastGrant] <= bus_rdata;
         end
      end
   end

   assign m0_busy   = slotFull[0];
   assign m1_busy   = slotFull[1];
   assign m0_ack    = ack[0];
   assign m1_ack    = ack[1];
   assign m0_rdata  = rdata[0];
   assign m1_rdata  = rdata[1];
   assign bus_addr  = busAddr;
   assign bus_we    = busWe;
   assign bus_wdata = busWdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench for bus_arbiter with a one-cycle-latency memory model.
`timescale 1ns/1ps
module tb_bus_arbiter;

   typedef struct {
      logic        we;
      logic [31:0] rdata;
   } expEnt_t;

   typedef struct {
      int m;
      int c;
   } ackRec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m0_lock, m0_busy, m0_ack;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic        m1_req, m1_we, m1_lock, m1_busy, m1_ack;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic        bus_we;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          weCount = 0;
   expEnt_t     expQ0 [$];
   expEnt_t     expQ1 [$];
   ackRec_t     ackAll [$];
   logic [31:0] lastRd [2];
   logic [31:0] mem [256];
   logic        memReady = 1'b0;
   int          c;

   always #5 clk = ~clk;

   bus_arbiter #(.DW(32), .AW(32), .MAX_LOCK(8), .LOCK_WAIT(4)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
      .m0_lock(m0_lock), .m0_busy(m0_busy), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
      .m1_lock(m1_lock), .m1_busy(m1_busy), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
   );

   function automatic logic [31:0] memDefault(input int i);
      return (i == 1) ? 32'hDEADBEEF : (32'hC0DE0000 + 32'(i));
   endfunction

   // Memory model: writes commit on the strobe edge, read data one cycle after the address
   always @(posedge clk) begin
      cyc++;
      if (!memReady) begin
         for (int i = 0; i < 256; i++) mem[i] <= memDefault(i);
         bus_rdata <= '0;
      end else begin
         if (bus_we) mem[bus_addr[9:2]] <= bus_wdata;
         bus_rdata <= mem[bus_addr[9:2]];
      end
   end

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic onAck(input int m, input logic [31:0] rd);
      expEnt_t e;
      ackRec_t r;
      int      sz;
      sz = (m == 0) ? expQ0.size() : expQ1.size();
      checkVal($sformatf("m%0d ack expected", m), 64'(sz != 0), 64'd1);
      if (sz != 0) begin
         if (m == 0) e = expQ0.pop_front();
         else        e = expQ1.pop_front();
         if (e.we) begin
            checkVal($sformatf("m%0d rdata held", m), 64'(rd), 64'(lastRd[m]));
         end else begin
            checkVal($sformatf("m%0d rdata", m), 64'(rd), 64'(e.rdata));
            lastRd[m] = e.rdata;
         end
      end
      r.m = m;
      r.c = cyc;
      ackAll.push_back(r);
   endtask

   // Output monitor: pops the scoreboard on every completion
   always @(negedge clk) begin
      if (bus_we) weCount++;
      if (m0_ack || m1_ack) checkVal("single ack", 64'({m0_ack, m1_ack} != 2'b11), 64'd1);
      if (m0_ack) onAck(0, m0_rdata);
      if (m1_ack) onAck(1, m1_rdata);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic reqM(input int m, input logic [31:0] addr, input logic we, input logic [31:0] wd,
                       input logic lk, input logic expAck, input logic [31:0] expRd);
      expEnt_t e;
      if (m == 0) begin
         m0_req = 1'b1; m0_addr = addr; m0_we = we; m0_wdata = wd; m0_lock = lk;
      end else begin
         m1_req = 1'b1; m1_addr = addr; m1_we = we; m1_wdata = wd; m1_lock = lk;
      end
      if (expAck) begin
         e.we    = we;
         e.rdata = expRd;
         if (m == 0) expQ0.push_back(e);
         else        expQ1.push_back(e);
      end
      @(posedge clk);
      #1;
      if (m == 0) m0_req = 1'b0;
      else        m1_req = 1'b0;
   endtask

   task automatic waitAck(input int m, input int budget);
      logic seen;
      int   n;
      seen = 1'b0;
      n    = 0;
      while (!seen && n < budget) begin
         @(posedge clk);
         #1;
         n++;
         seen = (m == 0) ? m0_ack : m1_ack;
      end
      checkVal($sformatf("m%0d ack in time", m), 64'(seen), 64'd1);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((expQ0.size() + expQ1.size()) != 0 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkVal("drain pending", 64'(expQ0.size() + expQ1.size()), 64'd0);
   endtask

   task automatic checkAck(input string tag, input int idx, input int m, input int cy);
      checkVal({tag, " present"}, 64'(ackAll.size() > idx), 64'd1);
      if (ackAll.size() > idx) begin
         checkVal({tag, " master"}, 64'(ackAll[idx].m), 64'(m));
         if (cy >= 0) checkVal({tag, " cycle"}, 64'(ackAll[idx].c), 64'(cy));
      end
   endtask

   task automatic doReset();
      reset  = 1'b0;
      m0_req = 1'b0; m0_addr = '0; m0_we = 1'b0; m0_wdata = '0; m0_lock = 1'b0;
      m1_req = 1'b0; m1_addr = '0; m1_we = 1'b0; m1_wdata = '0; m1_lock = 1'b0;
      expQ0.delete();
      expQ1.delete();
      lastRd[0] = '0;
      lastRd[1] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkVal("reset busy", 64'({m0_busy, m1_busy}), 64'd0);
      checkVal("reset ack", 64'({m0_ack, m1_ack}), 64'd0);
      checkVal("reset rdata", {m0_rdata, m1_rdata}, 64'd0);
      checkVal("reset bus", {bus_addr, bus_wdata}, 64'd0);
      checkVal("reset bus_we", 64'(bus_we), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      m0_req = 1'b0; m1_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      memReady = 1'b1;
      doReset();

      // Single read
      ackAll.delete(); weCount = 0; c = cyc;
      reqM(0, 32'h00010004, 1'b0, '0, 1'b0, 1'b1, 32'hDEADBEEF);
      @(negedge clk);
      checkVal("t1 busy", 64'(m0_busy), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      checkVal("t1 bus_addr", 64'(bus_addr), 64'h00010004);
      checkVal("t1 bus_we", 64'(bus_we), 64'd0);
      drain(20);
      checkAck("t1 ack", 0, 0, c + 4);
      checkVal("t1 we count", 64'(weCount), 64'd0);

      // Simultaneous requests after reset: master 0 wins the tie
      doReset();
      ackAll.delete(); weCount = 0; c = cyc;
      fork
         reqM(0, 32'h00010000, 1'b1, 32'h11, 1'b0, 1'b1, '0);
         reqM(1, 32'h00010000, 1'b0, '0, 1'b0, 1'b1, 32'h11);
      join
      @(posedge clk); #1;
      @(negedge clk);
      checkVal("t2 access we", 64'(bus_we), 64'd1);
      checkVal("t2 access wdata", 64'(bus_wdata), 64'h11);
      step(3);
      @(negedge clk);
      checkVal("t2 m1 access addr", 64'(bus_addr), 64'h00010000);
      checkVal("t2 m1 access we", 64'(bus_we), 64'd0);
      drain(20);
      checkAck("t2 ack0", 0, 0, c + 4);
      checkAck("t2 ack1", 1, 1, c + 7);
      checkVal("t2 we count", 64'(weCount), 64'd1);

      // Round-robin with slots refilled in each ack cycle
      step(4);
      ackAll.delete(); weCount = 0; c = cyc;
      fork
         begin
            for (int k = 0; k < 3; k++) begin
               reqM(0, 32'h00010100 + 32'(4 * k), 1'b1, 32'hA0 + 32'(k), 1'b0, 1'b1, '0);
               waitAck(0, 20);
            end
         end
         begin
            for (int k = 0; k < 3; k++) begin
               reqM(1, 32'h00010200 + 32'(4 * k), 1'b0, '0, 1'b0, 1'b1, 32'hC0DE0080 + 32'(k));
               waitAck(1, 20);
            end
         end
      join
      drain(20);
      for (int k = 0; k < 6; k++) checkAck($sformatf("rr ack%0d", k), k, k % 2, c + 4 + 3 * k);
      checkVal("rr we count", 64'(weCount), 64'd3);

      // Lock: master 1 holds the bus for MAX_LOCK grants while master 0 waits
      step(6);
      ackAll.delete(); weCount = 0; c = cyc;
      fork
         begin
            for (int k = 0; k < 10; k++) begin
               reqM(1, 32'h00010300 + 32'(4 * k), 1'b1, 32'hB0 + 32'(k), 1'b1, 1'b1, '0);
               waitAck(1, 40);
            end
         end
         begin
            @(posedge clk); #1;
            reqM(0, 32'h00010000, 1'b0, '0, 1'b0, 1'b1, 32'h11);
         end
      join
      drain(60);
      for (int k = 0; k < 11; k++) checkAck($sformatf("lock ack%0d", k), k, (k == 8) ? 0 : 1, -1);
      checkVal("lock we count", 64'(weCount), 64'd10);

      // Lock owner idle for LOCK_WAIT cycles loses the bus to pending master 0
      step(6);
      ackAll.delete(); c = cyc;
      fork
         reqM(1, 32'h00010008, 1'b1, 32'h22, 1'b1, 1'b1, '0);
         begin
            @(posedge clk); #1;
            reqM(0, 32'h00010008, 1'b0, '0, 1'b0, 1'b1, 32'h22);
         end
      join
      drain(40);
      checkAck("lockidle ack0", 0, 1, c + 4);
      checkAck("lockidle ack1", 1, 0, c + 10);

      // Request while busy is dropped
      step(6);
      ackAll.delete(); weCount = 0;
      reqM(0, 32'h0001000C, 1'b1, 32'h33, 1'b0, 1'b1, '0);
      @(negedge clk);
      checkVal("busy before repeat", 64'(m0_busy), 64'd1);
      @(posedge clk); #1;
      reqM(0, 32'h00010010, 1'b1, 32'h44, 1'b0, 1'b0, '0);
      drain(20);
      step(8);
      checkVal("busy drop acks", 64'(ackAll.size()), 64'd1);
      checkVal("busy drop we count", 64'(weCount), 64'd1);
      reqM(0, 32'h00010010, 1'b0, '0, 1'b0, 1'b1, 32'hC0DE0004);
      drain(20);

      // Reset during ACCESS of a write
      step(6);
      ackAll.delete(); c = cyc;
      reqM(0, 32'h00010080, 1'b1, 32'h77, 1'b0, 1'b0, '0);
      reqM(1, 32'h00010090, 1'b0, '0, 1'b0, 1'b0, '0);
      @(negedge clk);
      checkVal("mid access we", 64'(bus_we), 64'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkVal("mid reset bus_we", 64'(bus_we), 64'd0);
      checkVal("mid reset busy", 64'({m0_busy, m1_busy}), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      lastRd[0] = '0;
      lastRd[1] = '0;
      step(8);
      checkVal("mid reset no ack", 64'(ackAll.size()), 64'd0);
      c = cyc;
      reqM(0, 32'h00010084, 1'b0, '0, 1'b0, 1'b1, 32'hC0DE0021);
      drain(20);
      checkAck("post reset ack", 0, 0, c + 4);

      step(5);
      checkVal("final queues", 64'(expQ0.size() + expQ1.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter for the shared system bus: the CPU and a second master (DMA or debug loader) each post single-beat read/write requests, and the arbiter serialises them onto the one bus. The bus has one address/write-enable/write-data set and a memory/peripheral read path registered by one cycle. The arbiter sits between the masters and the address decoder/memory block. It provides one-deep request buffering per master, round-robin fairness and bounded bus locking.

## Interface
- DW, 32, data width
- AW, 32, address width
- MAX_LOCK, 8, max consecutive grants to a locking master
- LOCK_WAIT, 4, IDLE cycles a lock owner may leave its slot empty before the lock is dropped

- clk  in  1  clock
- reset  in  1  synchronous, active-low
- mN_req  in  1  request pulse, one cycle (N = 0, 1)
- mN_addr  in  AW  byte address, sampled with mN_req
- mN_we  in  1  1 = write, sampled with mN_req
- mN_wdata  in  DW  write data, sampled with mN_req
- mN_lock  in  1  keep grant after this transaction, sampled with mN_req
- mN_busy  out  1  request slot occupied
- mN_ack  out  1  one-cycle completion pulse
- mN_rdata  out  DW  read data, valid with mN_ack, held until the next read completion of that master
- bus_addr  out  AW  bus address
- bus_we  out  1  bus write strobe
- bus_wdata  out  DW  bus write data
- bus_rdata  in  DW  bus read data, valid one cycle after the address

## Operation
- **Request slots.** Each master has a slot holding {addr, we, wdata, lock} and a full flag; mN_busy = full.
  - mN_req with the slot empty: slot fills.
  - mN_req with the slot full: ignored, no ack ever issued for it.
  - A slot clears at the end of WAIT. A request arriving in the same cycle it clears is accepted (the fill wins).
- **FSM: IDLE → ACCESS → WAIT → IDLE.**
- **IDLE, no lock.** The eligible masters are those with a full slot.
  - Both eligible: grant goes to the master other than last_grant.
  - One eligible: grant goes to that master.
  - On a grant: copy the slot into the bus registers, set last_grant, go to ACCESS.
- **IDLE, lock held by master g.** Only g is eligible.
  - If g's slot stays empty for LOCK_WAIT consecutive IDLE cycles, the lock clears and arbitration proceeds in that same cycle.
- **ACCESS.** Drive bus_addr, bus_we = slot.we, bus_wdata. Go to WAIT.
- **WAIT.** bus_we = 0 and bus_addr is held. At the end of the cycle:
  - capture bus_rdata into mN_rdata (reads only);
  - set mN_ack for the next cycle and clear the slot;
  - lock update:
    - slot.lock = 1 and lock_count+1 < MAX_LOCK: lock owner = g, lock_count increments;
    - otherwise: lock clears and lock_count = 0.
  - Go to IDLE.
- **Idle bus.** Outside ACCESS/WAIT: bus_addr = 0, bus_we = 0, bus_wdata = 0.
- **Reset values** (reset = 0 at a clock edge):
  - state IDLE; both slots empty; all outputs 0;
  - last_grant = 1, so master 0 wins the first tie;
  - lock cleared, lock_count = 0, wait counter = 0.
  - An in-flight transaction is abandoned with no ack, and bus_we is 0 from the next cycle.

## Timing
- Request pulse in cycle 0:
  - slot full in cycle 1 (IDLE decision);
  - ACCESS in cycle 2 (bus driven; a write commits at the end of cycle 2);
  - WAIT in cycle 3;
  - mN_ack and mN_rdata in cycle 4.
  - Minimum latency is 4 cycles.
- Sustained throughput: one transaction per 3 cycles. IDLE coincides with the previous ack cycle.
- mN_ack never asserts for both masters in the same cycle.
- bus_we is high for exactly one cycle per write and never during a read.
- The bus registers change only on entering ACCESS, so address/data are stable for ACCESS and WAIT.
- After ack, a master may pulse req in the ack cycle. With a lock held, the next grant then happens in the following IDLE evaluation.

## Test plan
- **Single read.** m0 reads 0x00010004 with memory returning 0xDEADBEEF → bus_addr = 0x00010004 in cycle 2, m0_ack and m0_rdata = 0xDEADBEEF in cycle 4, bus_we never high.
- **Simultaneous requests.** Both masters pulse req in cycle 0 (m0 write 0x00010000 = 0x11, m1 read 0x00010000) → m0 granted first (reset tie-break), m0_ack in cycle 4; m1 in ACCESS in cycle 5 with ack and rdata = 0x11 in cycle 7.
- **Round-robin.** Both masters keep their slots refilled on every ack → grants alternate 0,1,0,1; neither master waits more than one other transaction.
- **Lock.** m1 issues 10 back-to-back locked writes while m0 is pending with MAX_LOCK = 8 → m1 gets 8 consecutive grants, then m0 is granted; a lock owner idle for 4 IDLE cycles loses the lock to the pending m0.
- **Busy drop.** m0 pulses req while m0_busy = 1 → second request ignored, exactly one m0_ack.
- **Reset mid-transfer.** reset = 0 during ACCESS of a write → no ack, bus_we = 0 and slots empty the next cycle; the first request after reset completes normally.
